// File: rtl/pe_mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_mesh_pkg
// Description : Shared types and constants for the pe_mesh convolution block.
//               Holds the job FSM state encoding, the streaming-mode codes and
//               the result-width helper used to size the accumulation path.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_mesh_pkg;

    // Job sequencing states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_FILL   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // Streaming modes; any other code streams horizontally and flags an error
    localparam logic [1:0] MODE_H = 2'b00;
    localparam logic [1:0] MODE_V = 2'b01;

    // Width that holds the sum of N*N full-scale unsigned products
    function automatic int acc_width(input int data_width, input int n);
        return 2 * data_width + $clog2(n * n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_row.sv
`default_nettype none
// ============================================================================
// Module      : pe_row
// Description : One mesh row. Registers N element-wise products of a window
//               row against a weight row, then registers their sum.
// Ports       : clk, rst_n  - clock, synchronous active-low reset
//               i_en        - pipeline advance; both stages hold when low
//               i_feat      - window row, element c at [c*DataWidth +: DataWidth]
//               i_wt        - weight row, same packing as i_feat
//               o_sum       - registered row sum, zero-extended to AccWidth
// Revision    : 1.0 - initial release
// ============================================================================
module pe_row
    import pe_mesh_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int N         = 11,
    parameter int AccWidth  = acc_width(DataWidth, N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [N*DataWidth-1:0] i_feat,
    input  logic [N*DataWidth-1:0] i_wt,
    output logic [AccWidth-1:0]    o_sum
);

    logic [2*DataWidth-1:0] r_prod [N];
    logic [AccWidth-1:0]    w_sum;

    always_comb begin
        w_sum = '0;
        for (int c = 0; c < N; c++) begin
            w_sum = w_sum + AccWidth'(r_prod[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N; c++) begin
                r_prod[c] <= '0;
            end
            o_sum <= '0;
        end else if (i_en) begin
            for (int c = 0; c < N; c++) begin
                r_prod[c] <= (2*DataWidth)'(i_feat[c*DataWidth +: DataWidth])
                           * (2*DataWidth)'(i_wt[c*DataWidth +: DataWidth]);
            end
            o_sum <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_mesh.sv
`default_nettype none
// ============================================================================
// Module      : pe_mesh
// Description : N x N sliding-window multiply-accumulate mesh. A job loads
//               N*N weights serially, then streams feature vectors into an
//               N x N window (column-wise or row-wise); every completed window
//               yields the sum of window*weight products three cycles later.
// Ports       : CLK, RST          - clock, synchronous active-low reset
//               start, mode       - begin a job from IDLE, mode latched with it
//               flush             - abort job (weights and mode_err retained)
//               w_valid/ready/data  - serial weight stream, row-major
//               if_valid/ready/data - one N-lane feature vector per beat
//               out_valid/ready/data- window results
//               busy, mode_err    - job active, sticky illegal-mode flag
// Revision    : 1.0 - initial release
// ============================================================================
module pe_mesh
    import pe_mesh_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int N         = 11,
    parameter int AccWidth  = acc_width(DataWidth, N)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   flush,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [DataWidth-1:0]   w_data,
    input  logic                   if_valid,
    output logic                   if_ready,
    input  logic [N*DataWidth-1:0] if_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AccWidth-1:0]    out_data,
    output logic                   busy,
    output logic                   mode_err
);

    localparam int                 c_idx_w    = $clog2(N);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_mode;
    logic                 r_mode_err;
    logic [c_idx_w-1:0]   r_wrow;
    logic [c_idx_w-1:0]   r_wcol;
    logic [c_idx_w-1:0]   r_fcnt;

    // Weights and window are stored one packed row per entry
    logic [N*DataWidth-1:0] r_w     [N];
    logic [N*DataWidth-1:0] r_win   [N];
    logic [N*DataWidth-1:0] w_win_h [N];
    logic [N*DataWidth-1:0] w_win_v [N];

    logic                 r_win_vld;
    logic                 r_prod_vld;
    logic                 r_sum_vld;
    logic                 r_out_valid;
    logic [AccWidth-1:0]  r_total;
    logic [AccWidth-1:0]  w_row_sum [N];
    logic [AccWidth-1:0]  w_total;

    logic w_adv;
    logic w_start;
    logic w_w_acc;
    logic w_w_last;
    logic w_if_acc;
    logic w_complete;

    // Single global stall: every stage moves only when the output slot frees
    assign w_adv      = !r_out_valid || out_ready;
    assign w_start    = (r_state == ST_IDLE) && start && !flush;
    assign w_w_acc    = (r_state == ST_LOAD_W) && w_valid;
    assign w_w_last   = w_w_acc && (r_wrow == c_idx_last) && (r_wcol == c_idx_last);
    assign w_if_acc   = if_valid && if_ready;
    assign w_complete = w_if_acc && ((r_state == ST_RUN) || (r_fcnt == c_idx_last));

    assign w_ready    = (r_state == ST_LOAD_W);
    assign if_ready   = ((r_state == ST_FILL) || (r_state == ST_RUN)) && w_adv;
    assign busy       = (r_state != ST_IDLE);
    assign mode_err   = r_mode_err;
    assign out_valid  = r_out_valid;
    assign out_data   = r_total;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start)    w_state_nxt = ST_LOAD_W;
                ST_LOAD_W: if (w_w_last) w_state_nxt = ST_FILL;
                ST_FILL:   if (w_complete) w_state_nxt = ST_RUN;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // ------------------------------------------------- control and counters
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_mode     <= MODE_H;
            r_mode_err <= 1'b0;
            r_wrow     <= '0;
            r_wcol     <= '0;
            r_fcnt     <= '0;
        end else begin
            if (w_start) begin
                r_mode     <= mode;
                r_mode_err <= mode[1];
            end
            if (flush || w_start) begin
                r_wrow <= '0;
                r_wcol <= '0;
            end else if (w_w_acc) begin
                if (r_wcol == c_idx_last) begin
                    r_wcol <= '0;
                    r_wrow <= (r_wrow == c_idx_last) ? '0 : r_wrow + 1'b1;
                end else begin
                    r_wcol <= r_wcol + 1'b1;
                end
            end
            if (flush) begin
                r_fcnt <= '0;
            end else if (w_if_acc && (r_state == ST_FILL)) begin
                r_fcnt <= (r_fcnt == c_idx_last) ? '0 : r_fcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------- weights
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int r = 0; r < N; r++) begin
                r_w[r] <= '0;
            end
        end else if (w_w_acc) begin
            for (int c = 0; c < N; c++) begin
                if (r_wcol == c_idx_w'(c)) begin
                    r_w[r_wrow][c*DataWidth +: DataWidth] <= w_data;
                end
            end
        end
    end

    // -------------------------------------------------------------- window
    // Horizontal: row r drops column 0 and takes vector lane r as column N-1.
    // Vertical:   rows move up one and the whole vector becomes row N-1.
    for (genvar gr = 0; gr < N; gr++) begin : g_win
        assign w_win_h[gr] = {if_data[gr*DataWidth +: DataWidth],
                              r_win[gr][N*DataWidth-1:DataWidth]};
        if (gr < N - 1) begin : g_shift_up
            assign w_win_v[gr] = r_win[gr+1];
        end else begin : g_insert_row
            assign w_win_v[gr] = if_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int r = 0; r < N; r++) begin
                r_win[r] <= '0;
            end
        end else if (w_if_acc) begin
            for (int r = 0; r < N; r++) begin
                r_win[r] <= (r_mode == MODE_V) ? w_win_v[r] : w_win_h[r];
            end
        end
    end

    // ------------------------------------------------------------ datapath
    for (genvar gr = 0; gr < N; gr++) begin : g_row
        pe_row #(
            .DataWidth (DataWidth),
            .N         (N),
            .AccWidth  (AccWidth)
        ) u_row (
            .clk    (CLK),
            .rst_n  (RST),
            .i_en   (w_adv),
            .i_feat (r_win[gr]),
            .i_wt   (r_w[gr]),
            .o_sum  (w_row_sum[gr])
        );
    end

    always_comb begin
        w_total = '0;
        for (int r = 0; r < N; r++) begin
            w_total = w_total + w_row_sum[r];
        end
    end

    // Valid bits track the window, product, row-sum and total stages
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_win_vld   <= 1'b0;
            r_prod_vld  <= 1'b0;
            r_sum_vld   <= 1'b0;
            r_out_valid <= 1'b0;
            r_total     <= '0;
        end else if (flush) begin
            r_win_vld   <= 1'b0;
            r_prod_vld  <= 1'b0;
            r_sum_vld   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_win_vld   <= w_complete;
            r_prod_vld  <= r_win_vld;
            r_sum_vld   <= r_prod_vld;
            r_out_valid <= r_sum_vld;
            if (r_sum_vld) begin
                r_total <= w_total;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mesh.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_mesh
// Description : Self-checking bench for pe_mesh (N=3, DataWidth=8). A small
//               window/weight model pushes expected results when a vector is
//               accepted; tasks pop and compare as results are delivered.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pe_mesh;

    localparam int DW = 8;
    localparam int NN = 3;
    localparam int AW = 2*DW + $clog2(NN*NN);

    logic            CLK = 1'b0;
    logic            RST = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      mode = 2'b00;
    logic            flush = 1'b0;
    logic            w_valid = 1'b0;
    logic [DW-1:0]   w_data = '0;
    logic            if_valid = 1'b0;
    logic [NN*DW-1:0] if_data = '0;
    logic            out_ready = 1'b1;
    logic            w_ready, if_ready, out_valid, busy, mode_err;
    logic [AW-1:0]   out_data;

    int checks = 0;
    int errors = 0;

    logic [7:0]    m_w   [3][3];
    logic [7:0]    m_win [3][3];
    int            m_fill = 0;
    logic          m_vert = 1'b0;
    logic [AW-1:0] exp_q [$];

    pe_mesh #(.DataWidth(DW), .N(NN)) dut (
        .CLK(CLK), .RST(RST), .start(start), .mode(mode), .flush(flush),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .if_valid(if_valid), .if_ready(if_ready), .if_data(if_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .mode_err(mode_err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] wgen(input int kind, input int k);
        if (kind == 0) return 8'd1;
        if (kind == 1) return 8'd255;
        return 8'((k * 37 + 5) & 255);
    endfunction

    // Reference window update; a completed window queues its expected sum
    function automatic void model_accept(input logic [23:0] d);
        logic [7:0] nw [3][3];
        int s;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (m_vert) begin
                    if (r == 2) nw[r][c] = d[c*8 +: 8];
                    else        nw[r][c] = m_win[r+1][c];
                end else begin
                    if (c == 2) nw[r][c] = d[r*8 +: 8];
                    else        nw[r][c] = m_win[r][c+1];
                end
            end
        end
        m_win = nw;
        m_fill++;
        if (m_fill >= 3) begin
            s = 0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    s += int'(m_win[r][c]) * int'(m_w[r][c]);
            exp_q.push_back(AW'(s));
        end
    endfunction

    task automatic do_start(input logic [1:0] md);
        @(negedge CLK); start = 1'b1; mode = md;
        @(negedge CLK); start = 1'b0; mode = 2'b00;
        m_vert = (md == 2'b01); m_fill = 0; exp_q.delete();
    endtask

    task automatic load_w(input int kind, output int nacc);
        nacc = 0;
        for (int cyc = 0; cyc < 40 && nacc < 9; cyc++) begin
            @(negedge CLK); w_valid = 1'b1; w_data = wgen(kind, nacc); #1;
            if (w_ready) begin
                m_w[nacc/3][nacc%3] = w_data;
                nacc++;
            end
        end
        @(negedge CLK); w_valid = 1'b0;
    endtask

    task automatic flush_job();
        @(negedge CLK); flush = 1'b1; if_valid = 1'b0; w_valid = 1'b0; start = 1'b0;
        @(negedge CLK); flush = 1'b0; out_ready = 1'b1;
        m_fill = 0; exp_q.delete();
    endtask

    // One clock of stream stimulus; reports acceptance and delivered output
    task automatic cycle(input logic v, input logic [23:0] d, input logic rdy,
                         output logic acc, output logic got, output logic [AW-1:0] data);
        @(negedge CLK); if_valid = v; if_data = d; out_ready = rdy; #1;
        got  = out_valid && out_ready;
        data = out_data;
        acc  = if_valid && if_ready;
        if (acc) model_accept(d);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, expected 0", out_data); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL reset_w_ready: got %b, expected 0", w_ready); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b, expected 0", if_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL reset_mode_err: got %b, expected 0", mode_err); end
        RST = 1'b1;
    endtask

    task automatic test_basic();
        logic [23:0]   vecs [4];
        logic [AW-1:0] outs [2];
        logic          acc, got;
        logic [AW-1:0] data, e;
        int ptr = 0, acc3 = -1, nout = 0, first = -1, second = -1, n;
        vecs[0] = {8'd3, 8'd2, 8'd1};
        vecs[1] = {8'd6, 8'd5, 8'd4};
        vecs[2] = {8'd9, 8'd8, 8'd7};
        vecs[3] = {8'd12, 8'd11, 8'd10};
        outs[0] = '0; outs[1] = '0;
        do_start(2'b00);
        load_w(0, n);
        checks++; if (n != 9) begin errors++; $display("FAIL basic_wbeats: got %0d, expected 9", n); end
        checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL basic_mode_err: got %b, expected 0", mode_err); end
        for (int i = 0; i < 12; i++) begin
            cycle(ptr < 4, vecs[ptr < 4 ? ptr : 0], 1'b1, acc, got, data);
            if (acc) begin
                if (ptr == 2) acc3 = i;
                ptr++;
            end
            if (got) begin
                if (nout == 0) first = i;
                if (nout == 1) second = i;
                if (nout < 2) outs[nout] = data;
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_out: got %0d, expected no output", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin errors++; $display("FAIL basic_out: got %0d, expected %0d", data, e); end
                end
            end
        end
        checks++; if (first != acc3 + 4) begin errors++; $display("FAIL basic_latency: got cycle %0d, expected %0d", first, acc3 + 4); end
        checks++; if (second != first + 1) begin errors++; $display("FAIL basic_throughput: got cycle %0d, expected %0d", second, first + 1); end
        checks++; if (nout != 2) begin errors++; $display("FAIL basic_count: got %0d, expected 2", nout); end
        checks++; if (outs[0] !== AW'(45)) begin errors++; $display("FAIL basic_45: got %0d, expected 45", outs[0]); end
        checks++; if (outs[1] !== AW'(72)) begin errors++; $display("FAIL basic_72: got %0d, expected 72", outs[1]); end
        flush_job();
    endtask

    task automatic test_max();
        logic acc, got;
        logic [AW-1:0] data, e;
        int ptr = 0, nout = 0, n;
        do_start(2'b00);
        load_w(1, n);
        for (int i = 0; i < 12; i++) begin
            cycle(ptr < 3, 24'hFFFFFF, 1'b1, acc, got, data);
            if (acc) ptr++;
            if (got) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL max_out: got %0d, expected no output", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin errors++; $display("FAIL max_out: got %0d, expected %0d", data, e); end
                end
                checks++;
                if (data !== AW'(585225)) begin errors++; $display("FAIL max_585225: got %0d, expected 585225", data); end
                nout++;
            end
        end
        checks++; if (nout != 1) begin errors++; $display("FAIL max_count: got %0d, expected 1", nout); end
        flush_job();
    endtask

    task automatic test_stall();
        logic [23:0]   vecs [8];
        logic          acc, got, rdy;
        logic [AW-1:0] data, e, held;
        int ptr = 0, nout = 0, n;
        for (int k = 0; k < 8; k++) vecs[k] = 24'($urandom);
        held = '0;
        do_start(2'b01);
        load_w(2, n);
        for (int i = 0; i < 40; i++) begin
            rdy = !(i >= 6 && i < 11);
            cycle(ptr < 8, vecs[ptr < 8 ? ptr : 0], rdy, acc, got, data);
            if (acc) ptr++;
            if (i == 6) begin
                held = data;
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b, expected 1", out_valid); end
            end
            if (!rdy) begin
                checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL stall_if_ready: got %b, expected 0", if_ready); end
                e = (exp_q.size() > 0) ? exp_q[0] : 'x;
                checks++; if (data !== held || data !== e) begin errors++; $display("FAIL stall_hold: got %0d, expected %0d", data, e); end
            end
            if (got) begin
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_out: got %0d, expected no output", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin errors++; $display("FAIL stall_out: got %0d, expected %0d", data, e); end
                end
            end
        end
        checks++; if (nout != 6) begin errors++; $display("FAIL stall_count: got %0d, expected 6", nout); end
        flush_job();
    endtask

    task automatic test_flush();
        int nacc = 0;
        do_start(2'b00);
        for (int cyc = 0; cyc < 20 && nacc < 4; cyc++) begin
            @(negedge CLK); w_valid = 1'b1; w_data = 8'd7; #1;
            if (w_ready) nacc++;
        end
        @(negedge CLK); w_valid = 1'b0; flush = 1'b1;
        @(negedge CLK); flush = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b, expected 0", busy); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL flush_w_ready: got %b, expected 0", w_ready); end
        @(negedge CLK); flush = 1'b1; start = 1'b1;
        @(negedge CLK); flush = 1'b0; start = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_wins: got busy %b, expected 0", busy); end
        do_start(2'b00);
        nacc = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge CLK); w_valid = 1'b1; w_data = 8'd1; #1;
            if (w_ready) nacc++;
        end
        @(negedge CLK); w_valid = 1'b0; #1;
        checks++; if (nacc != 9) begin errors++; $display("FAIL flush_reload_beats: got %0d, expected 9", nacc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_reload_busy: got %b, expected 1", busy); end
        flush_job();
    endtask

    task automatic test_mode_err();
        logic          acc, got;
        logic [AW-1:0] data, e;
        int ptr = 0, nout = 0, n;
        do_start(2'b11);
        #1;
        checks++; if (mode_err !== 1'b1) begin errors++; $display("FAIL moderr_set: got %b, expected 1", mode_err); end
        load_w(2, n);
        for (int i = 0; i < 12; i++) begin
            cycle(ptr < 5, {8'(ptr*3+2), 8'(ptr*5+1), 8'(ptr*11+9)}, 1'b1, acc, got, data);
            if (acc) ptr++;
            if (got) begin
                nout++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL moderr_out: got %0d, expected no output", data);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e) begin errors++; $display("FAIL moderr_out: got %0d, expected %0d", data, e); end
                end
            end
        end
        checks++; if (nout != 3) begin errors++; $display("FAIL moderr_count: got %0d, expected 3", nout); end
        @(negedge CLK); if_valid = 1'b1; if_data = 24'h010203; out_ready = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b, expected 1", out_valid); end
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_run_out_valid: got %b, expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_run_out_data: got %0d, expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy: got %b, expected 0", busy); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rst_run_if_ready: got %b, expected 0", if_ready); end
        checks++; if (w_ready !== 1'b0) begin errors++; $display("FAIL rst_run_w_ready: got %b, expected 0", w_ready); end
        checks++; if (mode_err !== 1'b0) begin errors++; $display("FAIL rst_run_mode_err: got %b, expected 0", mode_err); end
        @(negedge CLK); RST = 1'b1; if_valid = 1'b0; out_ready = 1'b1;
        m_fill = 0; exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_stall();
        test_flush();
        test_mode_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_mesh.md
PE_MESH -- requirements
Module: pe_mesh

Interface
REQ-001 SHALL have parameter DataWidth, default 8, meaning feature/weight element width in bits (unsigned).
REQ-002 SHALL have parameter N, default 11, meaning mesh side length; legal range 2..16.
REQ-003 SHALL have derived parameter AccWidth = 2*DataWidth + $clog2(N*N), meaning result width.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: begins a job from IDLE.
REQ-007 SHALL have port mode, input, 2 bits: streaming mode, sampled with start.
REQ-008 SHALL have port flush, input, 1 bit: aborts the job.
REQ-009 SHALL have ports w_valid (input, 1), w_ready (output, 1) and w_data (input, DataWidth): the serial weight stream.
REQ-010 SHALL have ports if_valid (input, 1), if_ready (output, 1) and if_data (input, N*DataWidth): one feature vector per beat, lane r at bits [r*DataWidth +: DataWidth].
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, AccWidth): window results.
REQ-012 SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-013 SHALL have port mode_err, output, 1 bit: sticky flag for an illegal mode.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_W, FILL and RUN.
REQ-015 IDLE -> LOAD_W on start; mode SHALL be latched at this transition; start outside IDLE SHALL be ignored.
REQ-016 In LOAD_W, w_ready=1; SHALL accept N*N beats, beat k -> W[k/N][k%N]; the last beat SHALL move to FILL.
REQ-017 In FILL/RUN, if_ready SHALL equal the pipeline advance (adv), where adv = !out_valid || out_ready; if_ready SHALL be 0 in IDLE/LOAD_W.
REQ-018 Mode 00 SHALL shift window columns left and insert the vector as column N-1.
REQ-019 Mode 01 SHALL shift window rows up and insert the vector as row N-1.
REQ-020 Modes 10/11 SHALL behave as 00 and set mode_err until reset or the next start.
REQ-021 FILL SHALL count accepted vectors; the N-th SHALL complete the first window and move to RUN; each vector accepted in RUN SHALL complete one window.
REQ-022 Pipeline SHALL be: products P[r][c] = window*W (2*DataWidth), then N row sums, then the total.
REQ-023 With no stall, out_valid SHALL rise 3 cycles after the accepting edge of the window-completing vector, at a throughput of one result per cycle.
REQ-024 When out_valid && !out_ready, all stages SHALL hold; out_data SHALL stay stable; no result SHALL be dropped or duplicated.
REQ-025 Arithmetic SHALL be unsigned and zero-extended to AccWidth; overflow SHALL be impossible by construction.
REQ-026 flush SHALL return the FSM to IDLE next cycle and clear all stage valids and the fill counter; weights and mode_err SHALL be retained.
REQ-027 If flush and start are asserted together, flush SHALL win.
REQ-028 RUN SHALL persist until flush; there is no frame-length counter.

Reset
REQ-029 RST low at any edge SHALL force IDLE, clear counters, stage valids, window and weights, and set out_valid=0, out_data=0, w_ready=0, if_ready=0, busy=0, mode_err=0.
REQ-030 Reset mid-job SHALL take effect with no drain.

Structure
REQ-031 Package pe_mesh_pkg SHALL hold the state enum, the mode encodings (MODE_H=2'b00, MODE_V=2'b01) and an AccWidth function.
REQ-032 A row sub-module pe_row SHALL hold N multipliers plus a registered row sum; pe_mesh SHALL instantiate N of them using generate.

Verification (N=3, DataWidth=8)
REQ-033 All weights 1, mode 00, vectors [1,2,3],[4,5,6],[7,8,9] -> out_data=45 three cycles after the third accept; then [10,11,12] -> 72 next cycle.
REQ-034 All weights 255, all features 255 -> out_data=585225, with no truncation at 20 bits.
REQ-035 out_ready held low 5 cycles during a RUN burst -> if_ready=0, out_data stable, and the later sequence complete and in order.
REQ-036 flush after 4 of 9 weight beats -> IDLE next cycle, busy=0; a new start re-enters LOAD_W expecting 9 beats.
REQ-037 start with mode=11 -> mode_err=1 and results equal to mode 00; RST low mid-RUN -> all outputs 0 next cycle.
